sdram_frame_sched: RTL and testbench

Parametrised SDRAM burst scheduler between the capture-side write FIFO, the display-side read FIFO and the single req/ack port pair of `sdram_top`. It replaces the fixed 128-row, single-frame write/read request machines in the top level. The block adds configurable burst/frame geometry, fair arbitration so at most one SDRAM transaction is outstanding, per-frame read restart, a late-frame flag and optional ping-pong frame buffering.

---
 rtl/sdram_frame_sched.sv | 147 ++++++++++++++
 tb/tb_sdram_frame_sched.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sdram_frame_sched.sv
// SDRAM burst scheduler: round-robin write/read bursts over one req/ack pair, per-frame read restart.
// Define SDRAM_SCHED_DBUF_EN for ping-pong frame buffering; default build is single-shot capture.
module sdram_frame_sched #(
   parameter int ADDR_W     = 24,
   parameter int COL_BITS   = 9,
   parameter int ROW_BITS   = 13,
   parameter int BUF_BIT    = 22,
   parameter int FRAME_ROWS = 128,
   parameter int LVL_W      = 11,
   parameter int WR_LVL_MIN = 512,
   parameter int RD_LVL_MAX = 512
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              frame_start_i,
   input  logic [LVL_W-1:0]  wr_fifo_used_i,
   input  logic [LVL_W-1:0]  rd_fifo_used_i,
   output logic              wr_sdram_req_o,
   input  logic              wr_sdram_ack_i,
   output logic [ADDR_W-1:0] wr_sdram_add_o,
   output logic              rd_sdram_req_o,
   input  logic              rd_sdram_ack_i,
   output logic [ADDR_W-1:0] rd_sdram_add_o,
   output logic              frame_valid_o,
   output logic              wr_frame_done_o,
   output logic              rd_late_o
);

   typedef enum logic [1:0] {IDLE, WR_BUSY, RD_BUSY} state_t;

   localparam logic [ROW_BITS:0]  ROWS_END = (ROW_BITS+1)'(FRAME_ROWS);
   localparam logic [LVL_W-1:0]   WR_MIN   = LVL_W'(WR_LVL_MIN);
   localparam logic [LVL_W-1:0]   RD_MAX   = LVL_W'(RD_LVL_MAX);

   state_t            state;
   logic [ROW_BITS:0] wr_row;
   logic [ROW_BITS:0] rd_row;
   logic              wbuf;
   logic              rbuf;
   logic              last_done_buf;
   logic              restart_pend;
   logic              last_rd;

   logic              we;
   logic              re;
   logic              wr_ack;
   logic              rd_ack;
   logic [ROW_BITS:0] wr_row_inc;
   logic              wr_wrap;
   logic              restart_now;
   logic              done_buf;

   always_comb begin
      we = (wr_fifo_used_i >= WR_MIN);
`ifndef SDRAM_SCHED_DBUF_EN
      we = we && !frame_valid_o;
`endif
      re          = frame_valid_o && (rd_row < ROWS_END) &&
                    (rd_fifo_used_i <= RD_MAX) && !restart_pend;
      wr_ack      = (state == WR_BUSY) && wr_sdram_ack_i;
      rd_ack      = (state == RD_BUSY) && rd_sdram_ack_i;
      wr_row_inc  = wr_row + 1'b1;
      wr_wrap     = wr_ack && (wr_row_inc == ROWS_END);
      // a pending or arriving restart waits out an in-flight read burst
      restart_now = (restart_pend || frame_start_i) && ((state != RD_BUSY) || rd_ack);
      done_buf    = wr_wrap ? wbuf : last_done_buf;
   end

   always_comb begin
      wr_sdram_add_o                      = '0;
      wr_sdram_add_o[COL_BITS +: ROW_BITS] = wr_row[ROW_BITS-1:0];
      wr_sdram_add_o[BUF_BIT]             = wbuf;
      rd_sdram_add_o                      = '0;
      rd_sdram_add_o[COL_BITS +: ROW_BITS] = rd_row[ROW_BITS-1:0];
      rd_sdram_add_o[BUF_BIT]             = rbuf;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state           <= IDLE;
         wr_row          <= '0;
         rd_row          <= '0;
         wbuf            <= 1'b0;
         rbuf            <= 1'b0;
         last_done_buf   <= 1'b0;
         restart_pend    <= 1'b0;
         last_rd         <= 1'b1;
         wr_sdram_req_o  <= 1'b0;
         rd_sdram_req_o  <= 1'b0;
         frame_valid_o   <= 1'b0;
         wr_frame_done_o <= 1'b0;
         rd_late_o       <= 1'b0;
      end else begin
         wr_frame_done_o <= 1'b0;
         rd_late_o       <= frame_start_i && frame_valid_o && (rd_row < ROWS_END);
         if (frame_start_i)
            restart_pend <= 1'b1;

         case (state)
            IDLE: begin
               if (we && (!re || last_rd)) begin
                  state          <= WR_BUSY;
                  wr_sdram_req_o <= 1'b1;
               end else if (re) begin
                  state          <= RD_BUSY;
                  rd_sdram_req_o <= 1'b1;
               end
            end
            WR_BUSY: begin
               if (wr_ack) begin
                  state          <= IDLE;
                  wr_sdram_req_o <= 1'b0;
                  last_rd        <= 1'b0;
                  if (wr_wrap) begin
                     wr_row          <= '0;
                     wr_frame_done_o <= 1'b1;
                     frame_valid_o   <= 1'b1;
                     last_done_buf   <= wbuf;
`ifdef SDRAM_SCHED_DBUF_EN
                     wbuf            <= ~wbuf;
`endif
                  end else begin
                     wr_row <= wr_row_inc;
                  end
               end
            end
            RD_BUSY: begin
               // rd_row saturates at FRAME_ROWS; only a restart rewinds it
               if (rd_ack) begin
                  state          <= IDLE;
                  rd_sdram_req_o <= 1'b0;
                  last_rd        <= 1'b1;
                  rd_row         <= rd_row + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase

         if (restart_now) begin
            rd_row       <= '0;
            rbuf         <= done_buf;
            restart_pend <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sdram_frame_sched.sv
// Directed bench for sdram_frame_sched with FRAME_ROWS=4; the DBUF section runs when SDRAM_SCHED_DBUF_EN is defined.
module tb_sdram_frame_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic        frame_start;
   logic [10:0] wr_used;
   logic [10:0] rd_used;
   logic        wr_req;
   logic        wr_ack;
   logic [23:0] wr_add;
   logic        rd_req;
   logic        rd_ack;
   logic [23:0] rd_add;
   logic        frame_valid;
   logic        wr_done;
   logic        rd_late;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   sdram_frame_sched #(.FRAME_ROWS(4)) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .frame_start_i   (frame_start),
      .wr_fifo_used_i  (wr_used),
      .rd_fifo_used_i  (rd_used),
      .wr_sdram_req_o  (wr_req),
      .wr_sdram_ack_i  (wr_ack),
      .wr_sdram_add_o  (wr_add),
      .rd_sdram_req_o  (rd_req),
      .rd_sdram_ack_i  (rd_ack),
      .rd_sdram_add_o  (rd_add),
      .frame_valid_o   (frame_valid),
      .wr_frame_done_o (wr_done),
      .rd_late_o       (rd_late)
   );

   typedef struct {
      logic        fs;
      logic [10:0] wu;
      logic [10:0] ru;
      logic        wa;
      logic        ra;
      logic [52:0] exp;
   } vec_t;

   localparam logic [10:0] HI = 11'd600;
   localparam logic [10:0] RB = 11'd513;
   localparam logic [10:0] RK = 11'd512;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
      n_vec++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, want);
      end
   endtask

   function automatic logic [52:0] outs();
      return {wr_req, rd_req, wr_add, rd_add, frame_valid, wr_done, rd_late};
   endfunction

   function automatic vec_t v(input logic fs, input logic [10:0] wu, input logic [10:0] ru,
                              input logic wa, input logic ra,
                              input logic ewr, input logic erd,
                              input logic [23:0] ewa, input logic [23:0] era,
                              input logic ev, input logic ed, input logic el);
      vec_t r;
      r.fs = fs; r.wu = wu; r.ru = ru; r.wa = wa; r.ra = ra;
      r.exp = {ewr, erd, ewa, era, ev, ed, el};
      return r;
   endfunction

   always @(negedge clk) begin
      if (!rst && (wr_req || rd_req))
         chk("both_req", {63'd0, wr_req & rd_req}, 64'd0);
   end

   task automatic serve(input string name, input logic exp_wr, input logic [23:0] exp_add);
      int unsigned n = 0;
      @(negedge clk);
      while (!(wr_req || rd_req) && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!(wr_req || rd_req)) begin
         chk({name, " timeout"}, 64'd1, 64'd0);
         return;
      end
      chk({name, " grant"}, {38'd0, wr_req, rd_req, (exp_wr ? wr_add : rd_add)},
          {38'd0, exp_wr, !exp_wr, exp_add});
      if (wr_req) wr_ack = 1'b1;
      else        rd_ack = 1'b1;
      @(posedge clk);
      #1;
      wr_ack = 1'b0;
      rd_ack = 1'b0;
      chk({name, " drop"}, {62'd0, wr_req, rd_req}, 64'd0);
   endtask

   initial begin
      vec_t tbl[28];
      rst = 1'b1; frame_start = 1'b0; wr_used = '0; rd_used = '0;
      wr_ack = 1'b0; rd_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset", {11'd0, outs()}, 64'd0);
      @(negedge clk);
      rst = 1'b0;

`ifndef SDRAM_SCHED_DBUF_EN
      tbl[0]  = v(0, HI, HI, 0, 0,  1, 0, 24'h000, 24'h000, 0, 0, 0);
      tbl[1]  = v(0, HI, HI, 1, 0,  0, 0, 24'h200, 24'h000, 0, 0, 0);
      tbl[2]  = v(0, HI, HI, 0, 0,  1, 0, 24'h200, 24'h000, 0, 0, 0);
      tbl[3]  = v(0, HI, HI, 1, 0,  0, 0, 24'h400, 24'h000, 0, 0, 0);
      tbl[4]  = v(0, HI, HI, 0, 0,  1, 0, 24'h400, 24'h000, 0, 0, 0);
      tbl[5]  = v(0, HI, HI, 1, 0,  0, 0, 24'h600, 24'h000, 0, 0, 0);
      tbl[6]  = v(0, HI, HI, 0, 0,  1, 0, 24'h600, 24'h000, 0, 0, 0);
      tbl[7]  = v(0, HI, HI, 1, 0,  0, 0, 24'h000, 24'h000, 1, 1, 0);
      tbl[8]  = v(0, HI, HI, 0, 0,  0, 0, 24'h000, 24'h000, 1, 0, 0);
      tbl[9]  = v(0, HI, RB, 1, 0,  0, 0, 24'h000, 24'h000, 1, 0, 0);
      tbl[10] = v(0, HI, RK, 0, 0,  0, 1, 24'h000, 24'h000, 1, 0, 0);
      tbl[11] = v(0, HI, RK, 0, 1,  0, 0, 24'h000, 24'h200, 1, 0, 0);
      tbl[12] = v(0, HI, RK, 0, 0,  0, 1, 24'h000, 24'h200, 1, 0, 0);
      tbl[13] = v(0, HI, RK, 0, 1,  0, 0, 24'h000, 24'h400, 1, 0, 0);
      tbl[14] = v(0, HI, RK, 0, 0,  0, 1, 24'h000, 24'h400, 1, 0, 0);
      tbl[15] = v(1, HI, RK, 0, 0,  0, 1, 24'h000, 24'h400, 1, 0, 1);
      tbl[16] = v(0, HI, RK, 0, 1,  0, 0, 24'h000, 24'h000, 1, 0, 0);
      tbl[17] = v(0, HI, RK, 0, 0,  0, 1, 24'h000, 24'h000, 1, 0, 0);
      tbl[18] = v(0, HI, RK, 0, 1,  0, 0, 24'h000, 24'h200, 1, 0, 0);
      tbl[19] = v(0, HI, RK, 0, 0,  0, 1, 24'h000, 24'h200, 1, 0, 0);
      tbl[20] = v(0, HI, RK, 0, 1,  0, 0, 24'h000, 24'h400, 1, 0, 0);
      tbl[21] = v(0, HI, RK, 0, 0,  0, 1, 24'h000, 24'h400, 1, 0, 0);
      tbl[22] = v(0, HI, RK, 0, 1,  0, 0, 24'h000, 24'h600, 1, 0, 0);
      tbl[23] = v(0, HI, RK, 0, 0,  0, 1, 24'h000, 24'h600, 1, 0, 0);
      tbl[24] = v(0, HI, RK, 0, 1,  0, 0, 24'h000, 24'h800, 1, 0, 0);
      tbl[25] = v(0, HI, RK, 0, 0,  0, 0, 24'h000, 24'h800, 1, 0, 0);
      tbl[26] = v(1, HI, RK, 0, 0,  0, 0, 24'h000, 24'h000, 1, 0, 0);
      tbl[27] = v(0, HI, RK, 0, 0,  0, 1, 24'h000, 24'h000, 1, 0, 0);

      for (int i = 0; i < 28; i++) begin
         @(negedge clk);
         frame_start = tbl[i].fs;
         wr_used     = tbl[i].wu;
         rd_used     = tbl[i].ru;
         wr_ack      = tbl[i].wa;
         rd_ack      = tbl[i].ra;
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d", i), {11'd0, outs()}, {11'd0, tbl[i].exp});
      end
      @(negedge clk);
      frame_start = 1'b0; wr_ack = 1'b0; rd_ack = 1'b0;
`else
      wr_used = HI; rd_used = HI;
      serve("w0", 1'b1, 24'h000000);
      serve("w1", 1'b1, 24'h000200);
      serve("w2", 1'b1, 24'h000400);
      serve("w3", 1'b1, 24'h000600);
      chk("dbuf_valid", {62'd0, frame_valid, wr_done}, {62'd0, 2'b11});
      wr_used = '0; frame_start = 1'b1;
      @(posedge clk);
      #1;
      frame_start = 1'b0; wr_used = HI; rd_used = RK;
      serve("rr_r0", 1'b0, 24'h000000);
      serve("rr_w4", 1'b1, 24'h400000);
      serve("rr_r1", 1'b0, 24'h000200);
      serve("rr_w5", 1'b1, 24'h400200);
      @(negedge clk);
      rd_used = HI;
`endif

      // asynchronous reset in the middle of a write burst
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; wr_used = HI; rd_used = HI;
      @(posedge clk);
      #1;
      chk("post_rst_req", {39'd0, wr_req, wr_add}, {39'd0, 1'b1, 24'h000000});
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_async_drop", {62'd0, wr_req, rd_req}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_valid_clear", {63'd0, frame_valid}, 64'd0);
      @(posedge clk);
      #1;
      chk("restart_addr0", {39'd0, wr_req, wr_add}, {39'd0, 1'b1, 24'h000000});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
